// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive arbiter slice.
package uart_pkg;

    localparam int unsigned DATA_W = 8;

    // Width of a channel index; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w = 1;
        while ((32'd1 << w) < n) w = w + 1;
        return w;
    endfunction

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/uart_rx_arbiter_if.sv
// Valid/ready byte stream carrying the source channel number with each byte.
interface uart_rx_arbiter_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = uart_pkg::DATA_W
);
    import uart_pkg::*;

    localparam int unsigned CH_W = clog2(NUM_CH);

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   ch;

    modport master (output valid, output data, output ch, input ready);
    modport slave  (input valid, input data, input ch, output ready);

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, ascending with wrap.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant_c,
    output logic [PW-1:0] grant_idx_c,
    output logic          any_c
);

    int unsigned idx;

    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        any_c       = 1'b0;
        idx         = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!any_c && req[idx]) begin
                any_c        = 1'b1;
                grant_c[idx] = 1'b1;
                grant_idx_c  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_rx_arbiter.sv
// Merges NUM_CH receiver byte streams into one tagged valid/ready port,
// with per-channel holding slots, overrun flags and a saturating drop counter.
module uart_rx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = uart_pkg::DATA_W,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_done,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH-1:0]        ovr_clr,
    output logic [NUM_CH-1:0]        ovr_flag,
    output logic [CNT_W-1:0]         ovr_count,
    uart_rx_arbiter_if.master        m
);

    localparam int unsigned CH_W  = clog2(NUM_CH);
    localparam int unsigned SUM_W = CNT_W + CH_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    out_state_e        state;
    logic [NUM_CH-1:0] hold_v;
    logic [DATA_W-1:0] hold_d [NUM_CH];
    logic [CH_W-1:0]   rr_ptr;
    logic [DATA_W-1:0] m_data_q;
    logic [CH_W-1:0]   m_ch_q;

    logic [NUM_CH-1:0] grant_c;
    logic [CH_W-1:0]   grant_idx_c;
    logic              any_c;
    logic              load_c;
    logic              grant_en_c;
    logic [NUM_CH-1:0] granted_c;
    logic [NUM_CH-1:0] cap_c;
    logic [NUM_CH-1:0] capture_c;
    logic [NUM_CH-1:0] ovr_c;
    logic [SUM_W-1:0]  ovr_sum_c;
    logic [CNT_W-1:0]  ovr_count_nx_c;

    rr_arbiter #(.N(NUM_CH)) u_rr (
        .req         (hold_v),
        .ptr         (rr_ptr),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c),
        .any_c       (any_c)
    );

    // Load/grant qualification, capture vs. overrun split, saturating drop sum.
    always_comb begin
        load_c     = (state == OUT_EMPTY) || m.ready;
        grant_en_c = load_c && any_c;
        granted_c  = grant_en_c ? grant_c : '0;
        cap_c      = ch_done & ch_en;
        capture_c  = cap_c & (~hold_v | granted_c);
        ovr_c      = cap_c & hold_v & ~granted_c;
        ovr_sum_c  = SUM_W'(ovr_count);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ovr_sum_c = ovr_sum_c + SUM_W'(ovr_c[i]);
        end
        ovr_count_nx_c = (ovr_sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(ovr_sum_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= OUT_EMPTY;
            hold_v    <= '0;
            rr_ptr    <= '0;
            m_data_q  <= '0;
            m_ch_q    <= '0;
            ovr_flag  <= '0;
            ovr_count <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                hold_d[i] <= '0;
            end
        end else begin
            hold_v <= (hold_v & ~granted_c) | capture_c;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (capture_c[i]) hold_d[i] <= ch_data[i*DATA_W +: DATA_W];
            end
            // A new overrun wins over a clear in the same cycle.
            ovr_flag  <= (ovr_flag & ~ovr_clr) | ovr_c;
            ovr_count <= ovr_count_nx_c;
            if (load_c) state <= any_c ? OUT_FULL : OUT_EMPTY;
            if (grant_en_c) begin
                m_data_q <= hold_d[grant_idx_c];
                m_ch_q   <= grant_idx_c;
                rr_ptr   <= (grant_idx_c == CH_W'(NUM_CH - 1)) ? '0 : grant_idx_c + CH_W'(1);
            end
        end
    end

    assign m.valid = (state == OUT_FULL);
    assign m.data  = m_data_q;
    assign m.ch    = m_ch_q;

endmodule

// File: doc/uart_rx_arbiter.md
# uart_rx_arbiter

Round-robin arbiter that merges the byte streams of NUM_CH UART receivers onto one valid/ready byte port for the downstream command/FIFO logic. Each receiver's single-cycle `done` pulse captures its byte into a one-entry per-channel holding register. A round-robin grant moves held bytes into a registered output stage tagged with the channel number. The block also provides per-channel enables, sticky per-channel overrun flags and a saturating global overrun counter.

## Interface
- NUM_CH, 4: number of receiver channels, 2..16
- DATA_W, 8: byte width
- CNT_W, 8: width of the global overrun counter
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clk
- ch_data  in  NUM_CH*DATA_W  receiver bytes; channel i occupies bits [i*DATA_W +: DATA_W]
- ch_done  in  NUM_CH  per-channel single-cycle byte-complete pulse
- ch_en  in  NUM_CH  per-channel enable; 0 ignores ch_done
- m_valid  out  1  output byte valid
- m_ready  in  1  downstream accepts
- m_data  out  DATA_W  output byte
- m_ch  out  $clog2(NUM_CH)  source channel of m_data
- ovr_flag  out  NUM_CH  sticky per-channel overrun flags
- ovr_clr  in  NUM_CH  per-channel flag clear (level, sampled each cycle)
- ovr_count  out  CNT_W  total dropped bytes, saturating

## Operation
- Holding register per channel: hold_v[i], hold_d[i].
- Capture: ch_done[i] && ch_en[i] with the slot free, or with the slot granted this cycle, gives hold_v[i] <= 1 and hold_d[i] <= ch_data[i].
- Overrun: ch_done[i] && ch_en[i] with hold_v[i]=1 and no grant to i this cycle.
  - The new byte is dropped and the old byte is kept.
  - ovr_flag[i] <= 1.
  - ovr_count increments by 1 and saturates at 2^CNT_W-1.
- Multiple channels overrunning in one cycle add their popcount to ovr_count, still saturating.
- ch_en[i]=0 does not discard a byte already held. That byte is still delivered.
- Output stage: two states, EMPTY (m_valid=0) and FULL (m_valid=1).
  - EMPTY goes to FULL when any hold_v is set.
  - FULL with m_ready=1 reloads if any hold_v is set, otherwise goes to EMPTY.
  - FULL with m_ready=0 holds; m_data and m_ch stay unchanged.
- Load condition: output EMPTY, or m_valid && m_ready.
- Arbitration on a load:
  - Search hold_v starting at rr_ptr, ascending with wrap.
  - The first set channel g is granted: m_data <= hold_d[g], m_ch <= g, hold_v[g] <= 0 unless re-captured the same cycle.
  - rr_ptr <= (g+1) mod NUM_CH.
- rr_ptr changes only on a grant.
- ovr_flag[i] clears when ovr_clr[i]=1. Set wins over clear in the same cycle.
- ovr_count clears only on reset.

## Timing
- Reset (async assert): m_valid=0, m_data=0, m_ch=0, ovr_flag=0, ovr_count=0, all hold_v=0, rr_ptr=0. Any in-flight held or output byte is lost.
- Latency: ch_done sampled at edge E0 sets hold_v after E0. Grant at E1 gives m_valid=1 after E1, so 2 cycles with no contention.
- Throughput: one byte per cycle while m_ready=1 and a hold_v is set.
- m_valid never deasserts without a handshake. m_data and m_ch are stable while m_valid && !m_ready.
- The m_ready combinational path reaches the load enable only. There is no path from m_ready to m_valid within the same cycle.
- Fairness: with all channels continuously pending, each channel is granted once every NUM_CH grants.

## Structure
- Shared package uart_pkg:
  - DATA_W default.
  - Channel-id typedef width function `clog2`.
  - Output-state enum {OUT_EMPTY, OUT_FULL}.
- Sub-module rr_arbiter:
  - Parameter N.
  - Ports: req[N], ptr, grant one-hot, grant index, any.
  - Purely combinational.
  - Instantiated once. rr_ptr register lives in the top.
- Top: holding registers, overrun logic, output stage, counter.

## Test plan
- Single byte: ch_done[2] with ch_data ch2=0xA5, m_ready=1 -> m_valid after 2 edges, m_data=0xA5, m_ch=2, one beat only.
- Simultaneous: all 4 channels pulse at once with 0x10..0x13, m_ready=1 -> four consecutive beats with m_ch=0,1,2,3. Then pulse again -> order continues from rr_ptr=0.
- Backpressure: m_ready=0 for 10 cycles while ch1 holds 0x55 in output and ch3 pending -> m_data/m_ch stable. On release, 0x55/ch1 then ch3 byte.
- Overrun: m_ready=0, ch0 pulses 0x01 then 0x02 then 0x03 -> ovr_flag[0]=1, ovr_count=1. On release the output delivers 0x01, then 0x02. ovr_clr[0] with a concurrent overrun -> flag stays 1.
- Saturation/enable: CNT_W=2, force 5 overruns -> ovr_count=3. ch_en[1]=0 pulses -> no capture, no count.
- Reset mid-stream: assert reset with m_valid=1 and two holds pending -> all outputs 0 immediately. After release, no stale beats are delivered.
